uart_tx_fifo: RTL and testbench

- Transmit-side buffer sitting directly upstream of the UART transmitter.
- Host/bus logic pushes data words; the transmitter pulls one word per completed frame.
- First-word-fall-through (FWFT) synchronous FIFO:
  - head word is always present on r_data while not empty.
  - empty drives the transmitter's FIFO-empty input, r_data its data input.
  - the transmitter's done tick drives rd.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_fifo_ctrl.sv | 113 +++++++++++
 rtl/uart_tx_fifo.sv | 61 ++++++
 tb/tb_uart_tx_fifo.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and the per-cycle FIFO operation encoding for the UART TX path.
// No ports: imported by uart_fifo_ctrl and uart_tx_fifo.
package uart_pkg;

   localparam int DBITS       = 8;
   localparam int FIFO_ADDR_W = 4;

   // Encoding of {wr_ok, rd_ok}
   typedef enum logic [1:0] {
      FIFO_NOP = 2'b00,
      FIFO_RD  = 2'b01,
      FIFO_WR  = 2'b10,
      FIFO_RW  = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: pointers, occupancy count, full/empty flags and accept logic.
// Ports: ckht, rst_n (async active-low); wr, rd requests; we, w_addr, r_addr
// to storage; empty, full, count status. Macro UART_TX_FIFO_ERR_EN adds
// err_clr input and sticky ovf/udf outputs.
module uart_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int ADDR_W = FIFO_ADDR_W
) (
   input  logic              ckht,
   input  logic              rst_n,
   input  logic              wr,
   input  logic              rd,
   output logic              we,
   output logic [ADDR_W-1:0] w_addr,
   output logic [ADDR_W-1:0] r_addr,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count
`ifdef UART_TX_FIFO_ERR_EN
   ,
   input  logic              err_clr,
   output logic              ovf,
   output logic              udf
`endif
);

   localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [ADDR_W-1:0] w_ptr, w_ptr_n;
   logic [ADDR_W-1:0] r_ptr, r_ptr_n;
   logic [ADDR_W:0]   cnt, cnt_n;
   logic              empty_q, empty_n;
   logic              full_q, full_n;
   logic              wr_ok, rd_ok;
   fifo_op_e          op;

   // A full FIFO still takes a write when the same cycle frees a slot
   assign wr_ok = wr & (~full_q | rd);
   assign rd_ok = rd & ~empty_q;
   assign op    = fifo_op_e'({wr_ok, rd_ok});

   always_ff @(posedge ckht or negedge rst_n) begin
      if (!rst_n) begin
         w_ptr   <= '0;
         r_ptr   <= '0;
         cnt     <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         w_ptr   <= w_ptr_n;
         r_ptr   <= r_ptr_n;
         cnt     <= cnt_n;
         empty_q <= empty_n;
         full_q  <= full_n;
      end
   end

   always_comb begin
      w_ptr_n = w_ptr;
      r_ptr_n = r_ptr;
      cnt_n   = cnt;
      empty_n = empty_q;
      full_n  = full_q;
      unique case (op)
         FIFO_WR: begin
            w_ptr_n = w_ptr + PTR_ONE;
            cnt_n   = cnt + CNT_ONE;
            empty_n = 1'b0;
            full_n  = (cnt == CNT_MAX - CNT_ONE);
         end
         FIFO_RD: begin
            r_ptr_n = r_ptr + PTR_ONE;
            cnt_n   = cnt - CNT_ONE;
            full_n  = 1'b0;
            empty_n = (cnt == CNT_ONE);
         end
         FIFO_RW: begin
            w_ptr_n = w_ptr + PTR_ONE;
            r_ptr_n = r_ptr + PTR_ONE;
         end
         default: ;
      endcase
   end

   assign we     = wr_ok;
   assign w_addr = w_ptr;
   assign r_addr = r_ptr;
   assign empty  = empty_q;
   assign full   = full_q;
   assign count  = cnt;

`ifdef UART_TX_FIFO_ERR_EN
   logic ovf_q, udf_q;

   // Set wins over a simultaneous clear
   always_ff @(posedge ckht or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= (wr & full_q & ~rd) | (ovf_q & ~err_clr);
         udf_q <= (rd & empty_q) | (udf_q & ~err_clr);
      end
   end

   assign ovf = ovf_q;
   assign udf = udf_q;
`endif

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FWFT transmit buffer feeding the UART transmitter.
// Ports: ckht, rst_n; wr/w_data push; rd pop; r_data head word; empty, full,
// count. Macro UART_TX_FIFO_ERR_EN adds err_clr, ovf, udf.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DW     = DBITS,
   parameter int ADDR_W = FIFO_ADDR_W
) (
   input  logic              ckht,
   input  logic              rst_n,
   input  logic              wr,
   input  logic [DW-1:0]     w_data,
   input  logic              rd,
   output logic [DW-1:0]     r_data,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count
`ifdef UART_TX_FIFO_ERR_EN
   ,
   input  logic              err_clr,
   output logic              ovf,
   output logic              udf
`endif
);

   logic              we;
   logic [ADDR_W-1:0] w_addr;
   logic [ADDR_W-1:0] r_addr;
   logic [DW-1:0]     mem [2**ADDR_W];

   uart_fifo_ctrl #(
      .ADDR_W (ADDR_W)
   ) u_ctrl (
      .ckht    (ckht),
      .rst_n   (rst_n),
      .wr      (wr),
      .rd      (rd),
      .we      (we),
      .w_addr  (w_addr),
      .r_addr  (r_addr),
      .empty   (empty),
      .full    (full),
      .count   (count)
`ifdef UART_TX_FIFO_ERR_EN
      ,
      .err_clr (err_clr),
      .ovf     (ovf),
      .udf     (udf)
`endif
   );

   // Storage carries no reset; empty qualifies the read data
   always_ff @(posedge ckht) begin
      if (we)
         mem[w_addr] <= w_data;
   end

   assign r_data = mem[r_addr];

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random checks of uart_tx_fifo against a queue model.
// Optional flags exercised when UART_TX_FIFO_ERR_EN is defined.
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;

   logic       ckht = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr = 1'b0;
   logic [7:0] w_data = '0;
   logic       rd = 1'b0;
   logic [7:0] r_data;
   logic       empty;
   logic       full;
   logic [4:0] count;
`ifdef UART_TX_FIFO_ERR_EN
   logic       err_clr = 1'b0;
   logic       ovf;
   logic       udf;
   logic       ovf_m = 1'b0;
   logic       udf_m = 1'b0;
`endif

   int n_assert = 0;
   int n_fail = 0;
   logic [7:0] mq[$];

   always #5 ckht = ~ckht;

   uart_tx_fifo dut (
      .ckht    (ckht),
      .rst_n   (rst_n),
      .wr      (wr),
      .w_data  (w_data),
      .rd      (rd),
      .r_data  (r_data),
      .empty   (empty),
      .full    (full),
      .count   (count)
`ifdef UART_TX_FIFO_ERR_EN
      ,
      .err_clr (err_clr),
      .ovf     (ovf),
      .udf     (udf)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      int sz;
      sz = mq.size();
      check({tag, ".empty"}, 32'(empty), 32'(sz == 0));
      check({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
      check({tag, ".count"}, 32'(count), 32'(sz));
      if (sz > 0)
         check({tag, ".r_data"}, 32'(r_data), 32'(mq[0]));
`ifdef UART_TX_FIFO_ERR_EN
      check({tag, ".ovf"}, 32'(ovf), 32'(ovf_m));
      check({tag, ".udf"}, 32'(udf), 32'(udf_m));
`endif
   endtask

   // Drive one clock of requests, then advance the model and compare
   task automatic cycle(input string tag, input logic w, input logic [7:0] d,
                        input logic r);
      int   sz;
      logic wok, rok;
`ifdef UART_TX_FIFO_ERR_EN
      logic oset, uset;
`endif
      wr = w;
      w_data = d;
      rd = r;
      sz = mq.size();
      wok = w && (sz < DEPTH || r);
      rok = r && (sz > 0);
`ifdef UART_TX_FIFO_ERR_EN
      oset = w && (sz == DEPTH) && !r;
      uset = r && (sz == 0);
`endif
      @(posedge ckht);
      #1;
      if (rok) void'(mq.pop_front());
      if (wok) mq.push_back(d);
`ifdef UART_TX_FIFO_ERR_EN
      ovf_m = oset | (ovf_m & ~err_clr);
      udf_m = uset | (udf_m & ~err_clr);
`endif
      check_state(tag);
   endtask

   initial begin
      repeat (3) @(posedge ckht);
      #1 rst_n = 1'b1;
      check_state("reset");
      for (int i = 0; i < 3; i++) cycle("idle_rd", 1'b0, 8'h00, 1'b1);
`ifdef UART_TX_FIFO_ERR_EN
      err_clr = 1'b1;
      cycle("udf_clr", 1'b0, 8'h00, 1'b0);
      err_clr = 1'b0;
`endif

      cycle("wr55", 1'b1, 8'h55, 1'b0);
      check("fwft_first", 32'(r_data), 32'h55);
      cycle("wrA3", 1'b1, 8'hA3, 1'b0);
      cycle("wr0F", 1'b1, 8'h0F, 1'b0);
      cycle("rd1", 1'b0, 8'h00, 1'b1);
      check("head_a3", 32'(r_data), 32'hA3);
      cycle("rd2", 1'b0, 8'h00, 1'b1);
      check("head_0f", 32'(r_data), 32'h0F);
      cycle("rd3", 1'b0, 8'h00, 1'b1);
      check("empty_after3", 32'(empty), 32'd1);

      for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 8'(i), 1'b0);
      check("full_at16", 32'(full), 32'd1);
      cycle("drop_ff", 1'b1, 8'hFF, 1'b0);
      check("count_drop", 32'(count), 32'd16);
`ifdef UART_TX_FIFO_ERR_EN
      check("ovf_set", 32'(ovf), 32'd1);
      cycle("ovf_hold", 1'b0, 8'h00, 1'b0);
      err_clr = 1'b1;
      cycle("ovf_clr", 1'b0, 8'h00, 1'b0);
      err_clr = 1'b0;
`endif
      for (int i = 0; i < 16; i++) begin
         check("drain_order", 32'(r_data), 32'(i));
         cycle("drain", 1'b0, 8'h00, 1'b1);
      end

      for (int i = 0; i < 16; i++) cycle("refill", 1'b1, 8'(8'h10 + i), 1'b0);
      cycle("rw_full", 1'b1, 8'h77, 1'b1);
      check("rw_full_cnt", 32'(count), 32'd16);
      for (int i = 0; i < 16; i++) cycle("drain77", 1'b0, 8'h00, 1'b1);

      cycle("rw_empty", 1'b1, 8'h3C, 1'b1);
      check("rw_empty_data", 32'(r_data), 32'h3C);
      cycle("pop3c", 1'b0, 8'h00, 1'b1);

      for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 8'(8'hA0 + i), 1'b0);
      cycle("tx_pop", 1'b0, 8'h00, 1'b1);
      rd = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      mq.delete();
`ifdef UART_TX_FIFO_ERR_EN
      ovf_m = 1'b0;
      udf_m = 1'b0;
`endif
      check("async_empty", 32'(empty), 32'd1);
      check("async_count", 32'(count), 32'd0);
      rd = 1'b0;
      @(posedge ckht);
      #1 rst_n = 1'b1;
      check_state("post_rst");
      cycle("wr81", 1'b1, 8'h81, 1'b0);
      check("r81", 32'(r_data), 32'h81);

      for (int ph = 0; ph < 3; ph++) begin
         int wp, rp;
         wp = (ph == 0) ? 85 : (ph == 1) ? 25 : 55;
         rp = (ph == 0) ? 25 : (ph == 1) ? 85 : 55;
         for (int i = 0; i < 150; i++) begin
`ifdef UART_TX_FIFO_ERR_EN
            err_clr = ($urandom_range(0, 9) == 0);
`endif
            cycle("rand",
                  $urandom_range(0, 99) < wp,
                  8'($urandom),
                  $urandom_range(0, 99) < rp);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
